// File: rtl/ibex_pmp_csr_regs.sv
// PMP CSR bank: pmpcfg0-3 / pmpaddr0-15 storage with lock and WARL legalization.
// Optional feature macro IBEX_PMP_ENCRYPT_EN stores the per-region encrypt bit (cfg bit 5).
package ibex_pmp_csr_regs_pkg;
   typedef enum logic [1:0] {
      PMP_MODE_OFF   = 2'd0,
      PMP_MODE_TOR   = 2'd1,
      PMP_MODE_NA4   = 2'd2,
      PMP_MODE_NAPOT = 2'd3
   } pmp_mode_e;

   typedef struct packed {
      logic      lock;
      pmp_mode_e mode;
      logic      exec;
      logic      write;
      logic      read;
      logic      encrypt;
   } pmp_cfg_t;
endpackage

module ibex_pmp_csr_regs
   import ibex_pmp_csr_regs_pkg::*;
#(
   parameter int unsigned PMPGranularity = 0,
   parameter int unsigned PMPNumRegions  = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        csr_access_i,
   input  logic        csr_we_i,
   input  logic [11:0] csr_addr_i,
   input  logic [31:0] csr_wdata_i,
   output logic        csr_hit_o,
   output logic [31:0] csr_rdata_o,
   output pmp_cfg_t    csr_pmp_cfg_o  [PMPNumRegions],
   output logic [33:0] csr_pmp_addr_o [PMPNumRegions],
   output logic        pmp_change_o
);

   // Read-back masks for coarse granularity; stored address bits are never altered.
   localparam logic [31:0] GRAN_CLR_MASK  = (PMPGranularity >= 1) ?
                                            ((32'd1 << PMPGranularity) - 32'd1) : 32'd0;
   localparam logic [31:0] NAPOT_SET_MASK = (PMPGranularity >= 2) ?
                                            ((32'd1 << (PMPGranularity - 1)) - 32'd1) : 32'd0;

   logic        is_cfg;
   logic        is_addr;
   logic        wr_en;
   pmp_cfg_t    cfg_cur  [16];
   logic [31:0] addr_cur [16];
   logic [15:0] cfg_wen;
   logic [15:0] addr_wen;
   logic        change_reg;
   logic [31:0] cfg_rdata;
   logic [31:0] addr_rdata;
   pmp_cfg_t    sel_cfg;
   logic [31:0] sel_addr;
   logic        unused_wdata;

   assign is_cfg    = (csr_addr_i[11:2] == 10'h0E8);
   assign is_addr   = (csr_addr_i[11:4] == 8'h3B);
   assign csr_hit_o = is_cfg | is_addr;
   assign wr_en     = csr_access_i & csr_we_i & csr_hit_o;

   // Reserved and unimplemented-region byte lanes are intentionally dropped.
   assign unused_wdata = ^csr_wdata_i;

   for (genvar gi = 0; gi < 16; gi++) begin : g_region
      if (gi < PMPNumRegions) begin : g_impl
         logic [7:0]  wbyte;
         logic        lock_reg;
         pmp_mode_e   mode_reg;
         logic        exec_reg;
         logic        write_reg;
         logic        read_reg;
         logic [31:0] addr_reg;
         logic        next_tor_locked;
         pmp_mode_e   mode_legal;
         logic        enc_bit;

         assign wbyte = csr_wdata_i[8*(gi%4) +: 8];
         assign cfg_wen[gi] = wr_en & is_cfg & (csr_addr_i[1:0] == 2'(gi/4)) & ~lock_reg;

         // A locked TOR region above uses this address as its base, so it is frozen too.
         if (gi + 1 < PMPNumRegions) begin : g_next
            assign next_tor_locked = cfg_cur[gi+1].lock & (cfg_cur[gi+1].mode == PMP_MODE_TOR);
         end else begin : g_last
            assign next_tor_locked = 1'b0;
         end

         assign addr_wen[gi] = wr_en & is_addr & (csr_addr_i[3:0] == 4'(gi)) &
                               ~lock_reg & ~next_tor_locked;

         assign mode_legal = (PMPGranularity >= 1 && wbyte[4:3] == 2'b10) ?
                             PMP_MODE_OFF : pmp_mode_e'(wbyte[4:3]);

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               lock_reg  <= 1'b0;
               mode_reg  <= PMP_MODE_OFF;
               exec_reg  <= 1'b0;
               write_reg <= 1'b0;
               read_reg  <= 1'b0;
            end else if (cfg_wen[gi]) begin
               lock_reg  <= wbyte[7];
               mode_reg  <= mode_legal;
               exec_reg  <= wbyte[2];
               write_reg <= wbyte[1] & wbyte[0];
               read_reg  <= wbyte[0];
            end
         end

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               addr_reg <= 32'd0;
            end else if (addr_wen[gi]) begin
               addr_reg <= csr_wdata_i;
            end
         end

`ifdef IBEX_PMP_ENCRYPT_EN
         logic enc_reg;
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               enc_reg <= 1'b0;
            end else if (cfg_wen[gi]) begin
               enc_reg <= wbyte[5];
            end
         end
         assign enc_bit = enc_reg;
`else
         assign enc_bit = 1'b0;
`endif

         assign cfg_cur[gi]        = {lock_reg, mode_reg, exec_reg, write_reg, read_reg, enc_bit};
         assign addr_cur[gi]       = addr_reg;
         assign csr_pmp_cfg_o[gi]  = cfg_cur[gi];
         assign csr_pmp_addr_o[gi] = {addr_reg, 2'b00};
      end else begin : g_absent
         assign cfg_cur[gi]  = '0;
         assign addr_cur[gi] = 32'd0;
         assign cfg_wen[gi]  = 1'b0;
         assign addr_wen[gi] = 1'b0;
      end
   end

   function automatic logic [7:0] cfg_byte(input pmp_cfg_t c);
      return {c.lock, 1'b0, c.encrypt, c.mode, c.exec, c.write, c.read};
   endfunction

   always_comb begin
      cfg_rdata = 32'd0;
      for (int k = 0; k < 4; k++) begin
         cfg_rdata[8*k +: 8] = cfg_byte(cfg_cur[{csr_addr_i[1:0], 2'(k)}]);
      end
      sel_cfg  = cfg_cur[csr_addr_i[3:0]];
      sel_addr = addr_cur[csr_addr_i[3:0]];
      if (sel_cfg.mode == PMP_MODE_NAPOT || sel_cfg.mode == PMP_MODE_NA4) begin
         addr_rdata = sel_addr | NAPOT_SET_MASK;
      end else begin
         addr_rdata = sel_addr & ~GRAN_CLR_MASK;
      end
   end

   assign csr_rdata_o = !csr_hit_o ? 32'd0 : (is_cfg ? cfg_rdata : addr_rdata);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         change_reg <= 1'b0;
      end else begin
         change_reg <= (|cfg_wen) | (|addr_wen);
      end
   end

   assign pmp_change_o = change_reg;

endmodule

// File: tb/tb_ibex_pmp_csr_regs.sv
// Directed bench for ibex_pmp_csr_regs: G=0 main instance plus a G=2 instance sharing stimulus.
module tb_ibex_pmp_csr_regs;
   import ibex_pmp_csr_regs_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        csr_access;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;

   logic        hit, hit2;
   logic [31:0] rdata, rdata2;
   pmp_cfg_t    cfg  [4];
   pmp_cfg_t    cfg2 [4];
   logic [33:0] paddr  [4];
   logic [33:0] paddr2 [4];
   logic        change, change2;

   int checks = 0;
   int errors = 0;

`ifdef IBEX_PMP_ENCRYPT_EN
   localparam logic [31:0] ENC_RD  = 32'h0000_0023;
   localparam logic        ENC_BIT = 1'b1;
`else
   localparam logic [31:0] ENC_RD  = 32'h0000_0003;
   localparam logic        ENC_BIT = 1'b0;
`endif

   ibex_pmp_csr_regs #(.PMPGranularity(0), .PMPNumRegions(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .csr_access_i(csr_access), .csr_we_i(csr_we),
      .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata), .csr_hit_o(hit), .csr_rdata_o(rdata),
      .csr_pmp_cfg_o(cfg), .csr_pmp_addr_o(paddr), .pmp_change_o(change)
   );

   ibex_pmp_csr_regs #(.PMPGranularity(2), .PMPNumRegions(4)) dut_g2 (
      .clk_i(clk), .rst_ni(rst_n), .csr_access_i(csr_access), .csr_we_i(csr_we),
      .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata), .csr_hit_o(hit2), .csr_rdata_o(rdata2),
      .csr_pmp_cfg_o(cfg2), .csr_pmp_addr_o(paddr2), .pmp_change_o(change2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_reset();
      csr_access = 1'b0; csr_we = 1'b0; csr_addr = 12'h000; csr_wdata = 32'd0;
      rst_n = 1'b0;
      #17;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Write occupies one cycle; returns 1ns after the capturing edge.
   task automatic do_write(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      csr_access = 1'b1; csr_we = 1'b1; csr_addr = a; csr_wdata = d;
      @(posedge clk);
      #1;
      csr_access = 1'b0; csr_we = 1'b0;
      $display("write addr=%h data=%h change=%b change_g2=%b", a, d, change, change2);
   endtask

   task automatic do_read(input logic [11:0] a, output logic [31:0] d, output logic [31:0] d2);
      @(negedge clk);
      csr_access = 1'b1; csr_we = 1'b0; csr_addr = a;
      #1;
      d = rdata; d2 = rdata2;
      csr_access = 1'b0;
      $display("read  addr=%h data=%h data_g2=%h", a, d, d2);
   endtask

   task automatic test_reset();
      logic [31:0] rd, rd2;
      apply_reset();
      do_read(12'h3A0, rd, rd2);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_cfg0: got %h want %h", rd, 32'h0); end
      do_read(12'h3B0, rd, rd2);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_addr0: got %h want %h", rd, 32'h0); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (cfg[i] !== pmp_cfg_t'('0)) begin errors++; $display("FAIL reset_cfg_out%0d: got %h want 0", i, cfg[i]); end
      end
      checks++; if (change !== 1'b0) begin errors++; $display("FAIL reset_change: got %b want 0", change); end
      do_read(12'h3C0, rd, rd2);
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL miss_hit: got %b want 0", hit); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL miss_rdata: got %h want 0", rd); end
   endtask

   task automatic test_cfg_write();
      logic [31:0] rd, rd2;
      do_write(12'h3A0, 32'h0000_0F1B);
      checks++; if (change !== 1'b1) begin errors++; $display("FAIL cfg_change_pulse: got %b want 1", change); end
      checks++; if (cfg[0].mode !== PMP_MODE_NAPOT) begin errors++; $display("FAIL cfg0_mode: got %0d want 3", cfg[0].mode); end
      checks++; if (cfg[1].mode !== PMP_MODE_TOR) begin errors++; $display("FAIL cfg1_mode: got %0d want 1", cfg[1].mode); end
      checks++; if (cfg[1].exec !== 1'b1) begin errors++; $display("FAIL cfg1_exec: got %b want 1", cfg[1].exec); end
      @(posedge clk); #1;
      checks++; if (change !== 1'b0) begin errors++; $display("FAIL cfg_change_one_cycle: got %b want 0", change); end
      do_read(12'h3A0, rd, rd2);
      checks++; if (rd !== 32'h0000_0F1B) begin errors++; $display("FAIL cfg_readback: got %h want %h", rd, 32'h0000_0F1B); end
   endtask

   task automatic test_warl();
      logic [31:0] rd, rd2;
      do_write(12'h3A0, 32'h0000_0002);
      checks++; if (change !== 1'b1) begin errors++; $display("FAIL warl_change: got %b want 1", change); end
      do_read(12'h3A0, rd, rd2);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL warl_w_no_r: got %h want 0", rd); end
      do_write(12'h3A0, 32'h0000_0006);
      do_read(12'h3A0, rd, rd2);
      checks++; if (rd !== 32'h0000_0004) begin errors++; $display("FAIL warl_xw_no_r: got %h want %h", rd, 32'h4); end
   endtask

   task automatic test_pmpaddr();
      logic [31:0] rd, rd2;
      do_write(12'h3B2, 32'hDEAD_BEEF);
      checks++; if (paddr[2] !== 34'h3_7AB6_FBBC) begin errors++; $display("FAIL addr2_out: got %h want %h", paddr[2], 34'h3_7AB6_FBBC); end
      do_read(12'h3B2, rd, rd2);
      checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL addr2_read: got %h want %h", rd, 32'hDEAD_BEEF); end
   endtask

   task automatic test_unimplemented();
      logic [31:0] rd, rd2;
      do_write(12'h3B5, 32'h0000_0055);
      checks++; if (change !== 1'b0) begin errors++; $display("FAIL unimpl_addr_change: got %b want 0", change); end
      do_read(12'h3B5, rd, rd2);
      checks++; if (hit !== 1'b1) begin errors++; $display("FAIL unimpl_hit: got %b want 1", hit); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unimpl_addr_read: got %h want 0", rd); end
      do_write(12'h3A1, 32'hFFFF_FFFF);
      checks++; if (change !== 1'b0) begin errors++; $display("FAIL unimpl_cfg_change: got %b want 0", change); end
      do_read(12'h3A1, rd, rd2);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unimpl_cfg_read: got %h want 0", rd); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      csr_access = 1'b1; csr_we = 1'b1; csr_addr = 12'h3B0; csr_wdata = 32'h0000_0011;
      @(posedge clk); #1;
      checks++; if (change !== 1'b1) begin errors++; $display("FAIL b2b_change_t1: got %b want 1", change); end
      @(negedge clk);
      csr_addr = 12'h3B1; csr_wdata = 32'h0000_0022;
      @(posedge clk); #1;
      csr_access = 1'b0; csr_we = 1'b0;
      checks++; if (change !== 1'b1) begin errors++; $display("FAIL b2b_change_t2: got %b want 1", change); end
      checks++; if (paddr[0] !== 34'h44 || paddr[1] !== 34'h88) begin
         errors++; $display("FAIL b2b_addrs: got %h/%h want 44/88", paddr[0], paddr[1]);
      end
      @(posedge clk); #1;
      checks++; if (change !== 1'b0) begin errors++; $display("FAIL b2b_change_t3: got %b want 0", change); end
      $display("back-to-back writes pmpaddr0=%h pmpaddr1=%h", paddr[0], paddr[1]);
   endtask

   task automatic test_read_during_write();
      do_write(12'h3B3, 32'h0000_000A);
      @(negedge clk);
      csr_access = 1'b1; csr_we = 1'b1; csr_addr = 12'h3B3; csr_wdata = 32'h0000_000B;
      #1;
      checks++; if (rdata !== 32'h0000_000A) begin errors++; $display("FAIL rd_during_wr: got %h want %h", rdata, 32'hA); end
      @(posedge clk); #1;
      csr_access = 1'b0; csr_we = 1'b0;
      checks++; if (paddr[3] !== 34'h2C) begin errors++; $display("FAIL rd_during_wr_new: got %h want %h", paddr[3], 34'h2C); end
      $display("read-during-write pmpaddr3=%h", paddr[3]);
   endtask

   task automatic test_lock();
      logic [31:0] rd, rd2;
      apply_reset();
      do_write(12'h3A0, 32'h0000_8900);
      checks++; if (cfg[1].lock !== 1'b1 || cfg[1].mode !== PMP_MODE_TOR) begin
         errors++; $display("FAIL lock_set: got lock=%b mode=%0d want 1/1", cfg[1].lock, cfg[1].mode);
      end
      do_write(12'h3B0, 32'h0000_1234);
      checks++; if (change !== 1'b0) begin errors++; $display("FAIL lock_tor_change: got %b want 0", change); end
      checks++; if (paddr[0] !== 34'h0) begin errors++; $display("FAIL lock_tor_addr0: got %h want 0", paddr[0]); end
      do_write(12'h3A0, 32'h0000_0000);
      checks++; if (change !== 1'b1) begin errors++; $display("FAIL lock_partial_change: got %b want 1", change); end
      do_read(12'h3A0, rd, rd2);
      checks++; if (rd !== 32'h0000_8900) begin errors++; $display("FAIL lock_sticky: got %h want %h", rd, 32'h8900); end
      do_write(12'h3B1, 32'h0000_0077);
      checks++; if (change !== 1'b0 || paddr[1] !== 34'h0) begin
         errors++; $display("FAIL lock_own_addr: got change=%b addr=%h want 0/0", change, paddr[1]);
      end
      do_write(12'h3B2, 32'h0000_0055);
      checks++; if (change !== 1'b1 || paddr[2] !== 34'h154) begin
         errors++; $display("FAIL lock_free_addr: got change=%b addr=%h want 1/154", change, paddr[2]);
      end
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++; if (cfg[1].lock !== 1'b0 || paddr[2] !== 34'h0) begin
         errors++; $display("FAIL async_reset: got lock=%b addr=%h want 0/0", cfg[1].lock, paddr[2]);
      end
      $display("async reset mid-cycle lock1=%b pmpaddr2=%h", cfg[1].lock, paddr[2]);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_granularity();
      logic [31:0] rd, rd2;
      apply_reset();
      do_write(12'h3B1, 32'h0000_1000);
      do_write(12'h3A0, 32'h0000_1800);
      do_read(12'h3B1, rd, rd2);
      checks++; if (hit2 !== 1'b1) begin errors++; $display("FAIL g2_hit: got %b want 1", hit2); end
      checks++; if (rd2 !== 32'h0000_1001) begin errors++; $display("FAIL g2_napot_read: got %h want %h", rd2, 32'h1001); end
      checks++; if (rd !== 32'h0000_1000) begin errors++; $display("FAIL g0_napot_read: got %h want %h", rd, 32'h1000); end
      do_write(12'h3B1, 32'h0000_1003);
      do_write(12'h3A0, 32'h0000_0000);
      do_read(12'h3B1, rd, rd2);
      checks++; if (rd2 !== 32'h0000_1000) begin errors++; $display("FAIL g2_off_read: got %h want %h", rd2, 32'h1000); end
      checks++; if (paddr2[1] !== 34'h400C) begin errors++; $display("FAIL g2_stored: got %h want %h", paddr2[1], 34'h400C); end
      do_write(12'h3A0, 32'h0000_1000);
      checks++; if (change2 !== 1'b1) begin errors++; $display("FAIL g2_na4_change: got %b want 1", change2); end
      checks++; if (cfg2[1].mode !== PMP_MODE_OFF) begin errors++; $display("FAIL g2_na4_mode: got %0d want 0", cfg2[1].mode); end
      checks++; if (cfg[1].mode !== PMP_MODE_NA4) begin errors++; $display("FAIL g0_na4_mode: got %0d want 2", cfg[1].mode); end
      do_read(12'h3A0, rd, rd2);
      checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL g2_na4_read: got %h want 0", rd2); end
   endtask

   task automatic test_encrypt();
      logic [31:0] rd, rd2;
      apply_reset();
      do_write(12'h3A0, 32'h0000_0023);
      checks++; if (cfg[0].encrypt !== ENC_BIT) begin errors++; $display("FAIL enc_bit: got %b want %b", cfg[0].encrypt, ENC_BIT); end
      checks++; if (cfg[0].write !== 1'b1 || cfg[0].read !== 1'b1) begin
         errors++; $display("FAIL enc_rw: got w=%b r=%b want 1/1", cfg[0].write, cfg[0].read);
      end
      do_read(12'h3A0, rd, rd2);
      checks++; if (rd !== ENC_RD) begin errors++; $display("FAIL enc_read: got %h want %h", rd, ENC_RD); end
   endtask

   initial begin
      test_reset();
      test_cfg_write();
      test_warl();
      test_pmpaddr();
      test_unimplemented();
      test_back_to_back();
      test_read_during_write();
      test_lock();
      test_granularity();
      test_encrypt();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ibex_pmp_csr_regs.md
# ibex_pmp_csr_regs

Holds the PMP configuration and address CSRs (pmpcfg0–3, pmpaddr0–15) and drives the per-region cfg/address buses consumed by the PMP checker. It sits beside the CSR file in the ID/EX stage: it accepts CSR reads and writes, enforces lock and WARL rules, and registers every update. It also emits a one-cycle change pulse so that fetch can flush prefetched instructions after a PMP reprogram.

## Interface
- PMPGranularity, 0: NAPOT granularity G; the granule is 2^(G+2) bytes.
- PMPNumRegions, 4: implemented regions, 1..16.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- csr_access_i  in  1  a CSR instruction is accessing csr_addr_i this cycle.
- csr_we_i  in  1  write strobe. Only valid with csr_access_i.
- csr_addr_i  in  12  CSR address.
- csr_wdata_i  in  32  write data, already merged for set/clear operations.
- csr_hit_o  out  1  csr_addr_i is in 0x3A0–0x3A3 or 0x3B0–0x3BF.
- csr_rdata_o  out  32  read data for csr_addr_i. Combinational.
- csr_pmp_cfg_o  out  pmp_cfg_t[PMPNumRegions]  registered region config: lock, mode, exec, write, read, encrypt.
- csr_pmp_addr_o  out  34[PMPNumRegions]  {pmpaddr[i][31:0], 2'b00}.
- pmp_change_o  out  1  one-cycle pulse after any effective write.

## Operation
- pmpcfgN (0x3A0+N) holds regions 4N..4N+3, one byte per region.
- Byte layout: bit7 lock, bit6 reserved (reads 0), bit5 encrypt, bits4:3 mode (OFF=0, TOR=1, NA4=2, NAPOT=3), bit2 X, bit1 W, bit0 R.
- pmpaddrI (0x3B0+I) stores a 32-bit value, which is PA[33:2].
- Regions with index ≥ PMPNumRegions:
  - read 0; writes are ignored.
  - csr_hit_o is still 1 and pmp_change_o does not pulse.
- Writes take effect only when csr_access_i & csr_we_i & csr_hit_o.
- Each pmpcfg byte is legalized independently before it is stored:
  - If the stored lock bit is 1, the byte write is ignored.
  - W=1 with R=0 is stored as W=0, R=0; X is kept.
  - Mode NA4 with PMPGranularity ≥ 1 is stored as OFF.
- A pmpaddrI write is ignored if either condition holds:
  - cfg[I].lock = 1;
  - I+1 < PMPNumRegions, cfg[I+1].lock = 1 and cfg[I+1].mode = TOR.
- pmpaddr read-back when PMPGranularity G ≥ 1:
  - mode NAPOT: bits [G-2:0] read as 1 (only when G ≥ 2);
  - mode OFF or TOR: bits [G-1:0] read as 0;
  - stored bits are unchanged by this.
- An effective write is one where at least one byte or address word is actually updated, even if the value is the same. It causes pmp_change_o = 1 in the following cycle.
- csr_rdata_o = 0 when csr_hit_o = 0.

## Timing
- Reset values: all cfg bytes 0 (mode OFF, unlocked), all pmpaddr 0, pmp_change_o = 0.
- Write in cycle T:
  - csr_pmp_cfg_o and csr_pmp_addr_o show the new value from T+1;
  - pmp_change_o is high for exactly cycle T+1.
- Read in the same cycle as a write returns the pre-write value.
- Back-to-back writes in T and T+1 give pmp_change_o high in T+1 and T+2.
- The lock check uses register state at the start of the cycle. A single pmpcfg write that sets L on region i+1 (TOR) does not block a pmpaddr[i] write in the same cycle; it blocks it from the next cycle on.
- Lock is sticky until reset. Reset asserted mid-operation clears all state asynchronously.

## Configuration
- IBEX_PMP_ENCRYPT_EN defined:
  - bit5 of each cfg byte is stored and read back;
  - the encrypt field of csr_pmp_cfg_o follows it.
- IBEX_PMP_ENCRYPT_EN undefined:
  - bit5 is reserved; it reads 0 and writes are dropped;
  - the encrypt field is tied to 0 and no storage is generated.

## Test plan
- After reset, read 0x3A0 and 0x3B0 -> 0x0000_0000 for both; all csr_pmp_cfg_o mode = OFF; pmp_change_o = 0.
- Write 0x3A0 = 0x0000_0F1B (region0 NAPOT RW, region1 TOR RWX) -> next cycle cfg[0].mode = NAPOT, cfg[1].mode = TOR, X=1; pmp_change_o pulses one cycle.
- Write 0x3A0 = 0x0000_0002 (W without R) -> read returns 0x0000_0000.
- Write 0x3A0 = 0x0000_8900 (region1 locked TOR), then write 0x3B0 = 0x1234 -> pmpaddr0 unchanged; a later write of 0x3A0 = 0 leaves region1 locked; pmp_change_o stays 0 for the ignored pmpaddr write.
- PMPGranularity = 2, pmpaddr1 = 0x0000_1000:
  - mode NAPOT -> read 0x0000_1001;
  - mode OFF -> read 0x0000_1000;
  - write NA4 -> mode reads OFF.
- With IBEX_PMP_ENCRYPT_EN: write 0x3A0 = 0x0000_0023 -> cfg[0].encrypt = 1, read 0x0000_0023. Without the macro: same write reads 0x0000_0003 and encrypt = 0.
